// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer for the single-cycle core.
// Optional misaligned-redirect trap is enabled by defining PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer #(
  parameter int unsigned                    AddressWidth = 10,
  parameter logic [AddressWidth-1:0]        ResetVector  = '0,
  parameter int unsigned                    InstretWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    halt_i,
  input  logic                    imem_ready_i,
  input  logic                    pc_src_sel_i,
  input  logic [AddressWidth-1:0] pc_target_i,
  output logic [AddressWidth-1:0] pc_o,
  output logic [AddressWidth-1:0] pc_plus4_o,
  output logic                    fetch_req_o,
  output logic                    retire_o,
  output logic                    halted_o,
  output logic                    fault_o,
  output logic [InstretWidth-1:0] instret_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [AddressWidth-1:0] pc_r;
  logic [AddressWidth-1:0] pc_next_s;
  logic [AddressWidth-1:0] pc_plus4_s;
  logic [AddressWidth-1:0] commit_target_s;
  logic [InstretWidth-1:0] instret_r;
  logic [InstretWidth-1:0] instret_next_s;
  logic                    fetch_req_s;
  logic                    misalign_s;
  logic                    retire_s;

  function automatic logic [AddressWidth-1:0] add4(input logic [AddressWidth-1:0] a);
    add4 = a + AddressWidth'(4);
  endfunction

  function automatic logic low_bits_set(input logic [AddressWidth-1:0] a);
    low_bits_set = (a[1:0] != 2'b00);
  endfunction

  // Fetch/retire qualification and the address committed on a redirect
  always_comb begin
    pc_plus4_s  = add4(pc_r);
    fetch_req_s = (state_r == ST_RUN) && en_i;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    misalign_s      = pc_src_sel_i && low_bits_set(pc_target_i);
    commit_target_s = pc_target_i;
`else
    misalign_s      = 1'b0;
    commit_target_s = {pc_target_i[AddressWidth-1:2], 2'b00};
`endif
    retire_s = fetch_req_s && imem_ready_i && !misalign_s;
  end

  // Next-state, next-PC and retire-count logic
  always_comb begin
    state_next_s   = state_r;
    pc_next_s      = pc_r;
    instret_next_s = instret_r;
    case (state_r)
      ST_IDLE: begin
        if (en_i) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_next_s = ST_IDLE;
        end else if (misalign_s && imem_ready_i) begin
          // Faulting instruction keeps its PC so software can inspect it
          state_next_s = ST_FAULT;
        end else if (retire_s) begin
          pc_next_s      = pc_src_sel_i ? commit_target_s : pc_plus4_s;
          instret_next_s = instret_r + InstretWidth'(1);
          if (halt_i) begin
            state_next_s = ST_HALT;
          end else begin
            state_next_s = ST_RUN;
          end
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALT: begin
        state_next_s = ST_HALT;
      end
      ST_FAULT: begin
        state_next_s = ST_FAULT;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State, PC and retired-instruction counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= ST_IDLE;
      pc_r      <= ResetVector;
      instret_r <= '0;
    end else begin
      state_r   <= state_next_s;
      pc_r      <= pc_next_s;
      instret_r <= instret_next_s;
    end
  end

  assign pc_o        = pc_r;
  assign pc_plus4_o  = pc_plus4_s;
  assign fetch_req_o = fetch_req_s;
  assign retire_o    = retire_s;
  assign halted_o    = (state_r == ST_HALT);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign fault_o     = (state_r == ST_FAULT);
`else
  assign fault_o     = 1'b0;
`endif
  assign instret_o   = instret_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised and directed bench for pc_sequencer against a spec-level model.
module tb_pc_sequencer;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 32;
  localparam logic [AW-1:0] RV = 10'h100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          halt = 1'b0;
  logic          rdy = 1'b0;
  logic          sel = 1'b0;
  logic [AW-1:0] tgt = '0;
  logic [AW-1:0] pc;
  logic [AW-1:0] pc4;
  logic          freq;
  logic          ret;
  logic          halted;
  logic          fault;
  logic [IW-1:0] instret;
  logic [1:0]    st;

  int n_cmp = 0;
  int n_err = 0;

  // Spec-level model: mode 0 idle, 1 run, 2 halt, 3 fault
  int          m_mode;
  int          m_pc;
  int unsigned m_instret;

  pc_sequencer #(.AddressWidth(AW), .ResetVector(RV), .InstretWidth(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .halt_i(halt),
    .imem_ready_i(rdy), .pc_src_sel_i(sel), .pc_target_i(tgt),
    .pc_o(pc), .pc_plus4_o(pc4), .fetch_req_o(freq), .retire_o(ret),
    .halted_o(halted), .fault_o(fault), .instret_o(instret), .state_o(st)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare and model advance, on the inactive edge
  always @(negedge clk) begin
    bit e_fr, e_mis, e_ret;
    if (!rst_n) begin
      m_mode = 0; m_pc = int'(RV); m_instret = 0;
    end
    e_fr = rst_n && (m_mode == 1) && en;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    e_mis = sel && (tgt % 4 != 0);
`else
    e_mis = 1'b0;
`endif
    e_ret = e_fr && rdy && !e_mis;
    check("pc", pc, m_pc);
    check("pc_plus4", pc4, (m_pc + 4) % (1 << AW));
    check("fetch_req", freq, e_fr);
    check("retire", ret, e_ret);
    check("halted", halted, m_mode == 2);
    check("fault", fault, m_mode == 3);
    check("instret", instret, m_instret);
    check("state", st, m_mode);
    if (rst_n) begin
      if (m_mode == 0) begin
        if (en) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!en) m_mode = 0;
        else if (rdy && e_mis) m_mode = 3;
        else if (rdy) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
          m_pc = sel ? int'(tgt) : (m_pc + 4) % (1 << AW);
`else
          m_pc = sel ? (int'(tgt) / 4) * 4 : (m_pc + 4) % (1 << AW);
`endif
          m_instret = m_instret + 1;
          if (halt) m_mode = 2;
        end
      end
    end
  end

  task automatic drive(input bit e, input bit r, input bit s, input logic [AW-1:0] t, input bit h);
    en = e; rdy = r; sel = s; tgt = t; halt = h;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Sequential fetch from the reset vector
    tick(2);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    rst_n = 1'b1;
    tick(4);
    check("seq_pc", pc, 10'h10C);
    check("seq_instret", instret, 3);
    // Memory stall holds the PC, then resumes
    drive(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
    tick(5);
    check("stall_pc", pc, 10'h10C);
    check("stall_instret", instret, 3);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    tick(1);
    check("resume_pc", pc, 10'h110);
    // Taken branches and wrap of PC+4
    drive(1'b1, 1'b1, 1'b1, 10'h020, 1'b0);
    tick(1);
    check("br_pc_020", pc, 10'h020);
    drive(1'b1, 1'b1, 1'b1, 10'h3F8, 1'b0);
    tick(1);
    check("br_pc_3f8", pc, 10'h3F8);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    tick(1);
    check("seq_pc_3fc", pc, 10'h3FC);
    tick(1);
    check("wrap_pc", pc, 10'h000);
    // Halt is sticky and ignores en
    drive(1'b1, 1'b1, 1'b1, 10'h010, 1'b0);
    tick(1);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b1);
    tick(1);
    check("halt_pc", pc, 10'h014);
    check("halt_state", st, 2'b10);
    check("halt_flag", halted, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(i[0], 1'b1, 1'b0, 10'h000, 1'b0);
      tick(1);
    end
    check("halt_sticky_state", st, 2'b10);
    check("halt_sticky_pc", pc, 10'h014);
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, RV);
    check("rst_state", st, 2'b00);
    check("rst_instret", instret, 0);
    // en dropped while ready: no retire, same PC refetched
    tick(1);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    rst_n = 1'b1;
    tick(2);
    check("pre_drop_pc", pc, 10'h104);
    drive(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    tick(1);
    check("drop_state", st, 2'b00);
    check("drop_pc", pc, 10'h104);
    check("drop_instret", instret, 1);
    drive(1'b1, 1'b1, 1'b0, 10'h000, 1'b0);
    tick(1);
    check("reen_pc", pc, 10'h104);
    tick(1);
    check("reen_next_pc", pc, 10'h108);
    // Misaligned redirect combined with halt
    drive(1'b1, 1'b1, 1'b1, 10'h046, 1'b1);
    tick(1);
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    check("mis_state", st, 2'b11);
    check("mis_fault", fault, 1'b1);
    check("mis_pc", pc, 10'h108);
    check("mis_instret", instret, 2);
`else
    check("mis_state", st, 2'b10);
    check("mis_pc", pc, 10'h044);
    check("mis_instret", instret, 3);
`endif
    drive(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
    tick(2);
    // Random traffic with occasional mid-operation resets
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      en   = ($urandom_range(0, 9) != 0);
      rdy  = ($urandom_range(0, 3) != 0);
      sel  = ($urandom_range(0, 3) == 0);
      tgt  = AW'($urandom);
      halt = ($urandom_range(0, 79) == 0);
      tick(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
